// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// cpu_pkg : shared state enum, control-bit indices and opcodes.  Rev 1.0
// ============================================================================
package cpu_pkg;

   typedef enum logic [3:0] {
      S_F0  = 4'd0,
      S_F1  = 4'd1,
      S_F2  = 4'd2,
      S_F3  = 4'd3,
      S_DEC = 4'd4,
      S_O0  = 4'd5,
      S_O1  = 4'd6,
      S_O2  = 4'd7,
      S_O3  = 4'd8,
      S_E0  = 4'd9,
      S_E1  = 4'd10,
      S_E2  = 4'd11,
      S_E3  = 4'd12,
      S_HLT = 4'd13
   } state_t;

   localparam int C0  = 0;
   localparam int C1  = 1;
   localparam int C2  = 2;
   localparam int C3  = 3;
   localparam int C4  = 4;
   localparam int C5  = 5;
   localparam int C6  = 6;
   localparam int C7  = 7;
   localparam int C8  = 8;
   localparam int C9  = 9;
   localparam int C10 = 10;
   localparam int C11 = 11;
   localparam int C12 = 12;

   localparam logic [7:0] OP_LOAD   = 8'h01;
   localparam logic [7:0] OP_STORE  = 8'h02;
   localparam logic [7:0] OP_ADD    = 8'h03;
   localparam logic [7:0] OP_SUB    = 8'h04;
   localparam logic [7:0] OP_JMP    = 8'h05;
   localparam logic [7:0] OP_JMPGEZ = 8'h06;
   localparam logic [7:0] OP_HALT   = 8'h07;

   // Opcodes that carry an address byte after the opcode byte.
   function automatic logic is_two_byte(input logic [7:0] op);
      return (op >= OP_LOAD) && (op <= OP_JMPGEZ);
   endfunction

endpackage
`default_nettype wire

// File: rtl/control_decode.sv
`default_nettype none
// ============================================================================
// control_decode : combinational map of state/opcode/sign to control bus.  Rev 1.0
// ============================================================================
module control_decode
   import cpu_pkg::*;
(
   input  state_t      state,
   input  logic [7:0]  ir_opcode,
   input  logic        acc_neg,
   output logic [31:0] control_signal
);

   always_comb begin
      control_signal = '0;
      case (state)
         S_F0, S_O0: control_signal[C2] = 1'b1;
         S_F1, S_O1: control_signal[C0] = 1'b1;
         S_F2, S_O2: control_signal[C1] = 1'b1;
         S_F3: begin
            control_signal[C5] = 1'b1;
            control_signal[C4] = 1'b1;
         end
         S_O3: begin
            if (ir_opcode == OP_JMP) begin
               control_signal[C6] = 1'b1;
            end else if (ir_opcode == OP_JMPGEZ) begin
               // Not taken: skip the address byte instead of loading PC.
               if (acc_neg) control_signal[C4] = 1'b1;
               else         control_signal[C6] = 1'b1;
            end else begin
               control_signal[C8] = 1'b1;
               control_signal[C4] = 1'b1;
            end
         end
         S_E0: begin
            control_signal[C0] = 1'b1;
            if (ir_opcode == OP_STORE) control_signal[C9] = 1'b1;
         end
         S_E1: begin
            if (ir_opcode == OP_STORE) control_signal[C3] = 1'b1;
            else                       control_signal[C1] = 1'b1;
         end
         S_E2: control_signal[C7] = 1'b1;
         S_E3: begin
            if (ir_opcode == OP_LOAD)     control_signal[C10] = 1'b1;
            else if (ir_opcode == OP_ADD) control_signal[C11] = 1'b1;
            else if (ir_opcode == OP_SUB) control_signal[C12] = 1'b1;
         end
         default: control_signal = '0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// control_sequencer : hardwired fetch/operand/execute FSM for the accumulator CPU.
// Define CU_MEM_WAIT_EN to stall F2/O2/E1 on mem_ready.  Rev 1.0
// ============================================================================
module control_sequencer
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  ir_opcode,
   input  logic        acc_neg,
   input  logic        mem_ready,
   output logic [31:0] control_signal,
   output logic        halted,
   output logic [3:0]  state_dbg
);

   state_t      state;
   state_t      state_next;
   logic        started;
   logic        mem_go;
   logic [31:0] decoded;

`ifdef CU_MEM_WAIT_EN
   assign mem_go = mem_ready;
`else
   logic unused_mem_ready;
   assign unused_mem_ready = mem_ready;
   assign mem_go           = 1'b1;
`endif

   // The first edge after reset release only arms the bus; F0 is held one extra cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= S_F0;
         started <= 1'b0;
      end else begin
         started <= 1'b1;
         if (started) state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         S_F0:  state_next = S_F1;
         S_F1:  state_next = S_F2;
         S_F2:  if (mem_go) state_next = S_F3;
         S_F3:  state_next = S_DEC;
         S_DEC: begin
            if (ir_opcode == OP_HALT)      state_next = S_HLT;
            else if (is_two_byte(ir_opcode)) state_next = S_O0;
            else                           state_next = S_F0;
         end
         S_O0:  state_next = S_O1;
         S_O1:  state_next = S_O2;
         S_O2:  if (mem_go) state_next = S_O3;
         S_O3: begin
            if ((ir_opcode == OP_JMP) || (ir_opcode == OP_JMPGEZ)) state_next = S_F0;
            else                                                   state_next = S_E0;
         end
         S_E0:  state_next = S_E1;
         S_E1: begin
            if (mem_go) state_next = (ir_opcode == OP_STORE) ? S_F0 : S_E2;
         end
         S_E2:  state_next = S_E3;
         S_E3:  state_next = S_F0;
         S_HLT: state_next = S_HLT;
         default: state_next = S_F0;
      endcase
   end

   control_decode u_decode (
      .state          (state),
      .ir_opcode      (ir_opcode),
      .acc_neg        (acc_neg),
      .control_signal (decoded)
   );

   assign control_signal = started ? decoded : '0;
   assign halted         = (state == S_HLT);
   assign state_dbg      = state;

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
// tb_control_sequencer : directed scoreboard bench for control_sequencer.  Rev 1.0
// ============================================================================
module tb_control_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  ir_opcode;
   logic        acc_neg;
   logic        mem_ready;
   logic [31:0] control_signal;
   logic        halted;
   logic [3:0]  state_dbg;

   int nvec  = 0;
   int nfail = 0;

   typedef struct {
      logic [3:0]  st;
      logic [31:0] ctrl;
      logic        hlt;
      logic        rdy;
   } exp_t;

   exp_t sbq[$];

   control_sequencer dut (
      .clk            (clk),
      .rst            (rst),
      .ir_opcode      (ir_opcode),
      .acc_neg        (acc_neg),
      .mem_ready      (mem_ready),
      .control_signal (control_signal),
      .halted         (halted),
      .state_dbg      (state_dbg)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp)
      else begin
         nfail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [3:0] st, input logic [31:0] ctrl,
                       input logic hlt = 1'b0, input logic rdy = 1'b1);
      exp_t e;
      e.st = st; e.ctrl = ctrl; e.hlt = hlt; e.rdy = rdy;
      sbq.push_back(e);
   endtask

   // A wait state stretched by n cycles of mem_ready low.
   task automatic push_wait(input logic [3:0] st, input logic [31:0] ctrl, input int n);
`ifdef CU_MEM_WAIT_EN
      for (int i = 0; i < n; i++) push(st, ctrl, 1'b0, 1'b0);
      push(st, ctrl, 1'b0, 1'b1);
`else
      push(st, ctrl, 1'b0, (n > 0) ? 1'b0 : 1'b1);
`endif
   endtask

   task automatic load_instr(input logic [7:0] op, input logic neg,
                             input int f2w = 0, input int o2w = 0, input int e1w = 0);
      ir_opcode = op;
      acc_neg   = neg;
      push(4'd0, 32'h004);
      push(4'd1, 32'h001);
      push_wait(4'd2, 32'h002, f2w);
      push(4'd3, 32'h030);
      push(4'd4, 32'h000);
      if (op >= 8'h01 && op <= 8'h06) begin
         push(4'd5, 32'h004);
         push(4'd6, 32'h001);
         push_wait(4'd7, 32'h002, o2w);
         case (op)
            8'h05: push(4'd8, 32'h040);
            8'h06: push(4'd8, neg ? 32'h010 : 32'h040);
            default: begin
               push(4'd8, 32'h110);
               push(4'd9, (op == 8'h02) ? 32'h201 : 32'h001);
               push_wait(4'd10, (op == 8'h02) ? 32'h008 : 32'h002, e1w);
               if (op != 8'h02) begin
                  push(4'd11, 32'h080);
                  push(4'd12, (op == 8'h01) ? 32'h400 : (op == 8'h03) ? 32'h800 : 32'h1000);
               end
            end
         endcase
      end
   endtask

   task automatic check_front(input string tag);
      exp_t e;
      e = sbq.pop_front();
      chk({tag, " state"}, {28'd0, state_dbg}, {28'd0, e.st});
      chk({tag, " ctrl"}, control_signal, e.ctrl);
      chk({tag, " halted"}, {31'd0, halted}, {31'd0, e.hlt});
      mem_ready = e.rdy;
   endtask

   task automatic drain(input string tag);
      while (sbq.size() > 0) begin
         check_front(tag);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_reset(input string tag);
      chk({tag, " state"}, {28'd0, state_dbg}, 32'd0);
      chk({tag, " ctrl"}, control_signal, 32'h0);
      chk({tag, " halted"}, {31'd0, halted}, 32'd0);
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("armed ctrl", control_signal, 32'h0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst       = 1'b0;
      ir_opcode = 8'h05;
      acc_neg   = 1'b0;
      mem_ready = 1'b1;
      #3;
      check_reset("reset");
      repeat (2) @(posedge clk);
      #1;
      check_reset("reset held");
      release_reset();

      load_instr(8'h05, 1'b0);           drain("jmp");
      load_instr(8'h01, 1'b0);           drain("load");
      load_instr(8'h02, 1'b0, 0, 0, 3);  drain("store wait");
      load_instr(8'h03, 1'b1, 1, 2, 0);  drain("add wait");
      load_instr(8'h04, 1'b0);           drain("sub");
      load_instr(8'h06, 1'b1);           drain("jmpgez neg");
      load_instr(8'h06, 1'b0);           drain("jmpgez pos");
      load_instr(8'h00, 1'b0);           drain("nop 00");
      load_instr(8'hFF, 1'b1);           drain("nop ff");

      // Reset pulse while ADD is in O2.
      load_instr(8'h03, 1'b0);
      repeat (7) begin
         check_front("add pre");
         @(posedge clk);
         #1;
      end
      check_front("add o2");
      #2;
      rst = 1'b0;
      #1;
      check_reset("async mid");
      sbq.delete();
      release_reset();
      load_instr(8'h01, 1'b0);           drain("load after rst");

      load_instr(8'h07, 1'b0);
      repeat (20) push(4'd13, 32'h0, 1'b1, 1'b1);
      drain("halt");
      #2;
      rst = 1'b0;
      #1;
      check_reset("halt rst");
      release_reset();
      load_instr(8'h04, 1'b1);           drain("sub after halt");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
`default_nettype wire
